// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the IF/ID hazard controller: state encoding, instruction field
// positions and the canned control-output patterns.
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] LSTALL = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_STALL  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_WAIT   = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF; async active-low reset plus sync clear.
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 16'h0000;
        end else if (clear) begin
            count <= 16'h0000;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing for load-use stalls, taken-branch flushes and imem waits.
// Statistics counters are built only when IF_ID_HAZARD_STATS_EN is defined.
//
// state  | meaning
// RUN    | normal issue; hazards answered combinationally in the same cycle
// LSTALL | remaining load-use bubble cycles, cnt counts down to 1
// FLUSH  | remaining squash cycles after a taken branch, cnt counts down to 1
module if_id_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int REG_ADDR_W        = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           ifid_instr,
    input  logic                  ifid_uses_rt,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [15:0]           stall_count,
    output logic [15:0]           flush_count
);

    logic [1:0]            state, state_nxt;
    logic [1:0]            cnt, cnt_nxt;
    logic                  rst_active;
    logic                  in_reset;
    logic                  lu, br, br_acc;
    logic [REG_ADDR_W-1:0] rs_f, rt_f;
    ctrl_t                 ctrl;
    logic                  unused_instr_bits;

    assign rs_f = REG_ADDR_W'(ifid_instr[RS_MSB:RS_LSB]);
    assign rt_f = REG_ADDR_W'(ifid_instr[RT_MSB:RT_LSB]);
    assign unused_instr_bits = ^{ifid_instr[31:26], ifid_instr[15:0]};

    assign lu = idex_mem_read && (idex_rt != '0) &&
                ((idex_rt == rs_f) || (ifid_uses_rt && (idex_rt == rt_f)));
    assign br = ex_branch_taken;

    // rst_active keeps the reset outputs until the first edge after release
    assign in_reset = rst_active || !reset;

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        cnt_nxt   = cnt;
        br_acc    = 1'b0;
        if (in_reset) begin
            ctrl      = CTRL_RESET;
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else if (br) begin
            ctrl   = CTRL_BRANCH;
            br_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = 2'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        end else begin
            case (state)
                LSTALL: begin
                    ctrl    = CTRL_STALL;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = RUN;
                end
                FLUSH: begin
                    ctrl       = CTRL_BRANCH;
                    ctrl.pc_we = imem_ready;
                    cnt_nxt    = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = RUN;
                end
                default: begin
                    if (lu) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = 2'(LOAD_STALL_CYCLES - 1);
                        end
                    end else if (!imem_ready) begin
                        ctrl = CTRL_WAIT;
                    end else begin
                        ctrl = CTRL_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cnt        <= 2'd0;
            rst_active <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rst_active <= 1'b0;
        end
    end

    assign pc_write_en    = ctrl.pc_we;
    assign if_id_write_en = ctrl.ifid_we;
    assign if_id_flush    = ctrl.ifid_flush;
    assign id_ex_bubble   = ctrl.idex_bubble;

`ifdef IF_ID_HAZARD_STATS_EN
    sat_counter16 u_stall_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (rst_active),
        .enable (!in_reset && !ctrl.pc_we),
        .count  (stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (rst_active),
        .enable (br_acc),
        .count  (flush_count)
    );
`else
    logic unused_stats;
    assign unused_stats = br_acc;
    assign stall_count  = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule
